// File: rtl/video_pkg.sv
// Shared constants for the VIP test pattern generator: packet types, pattern
// encodings, bar colour table and the generator FSM state type.
package video_pkg;

    localparam logic [3:0] VIP_TYPE_VIDEO     = 4'h0;
    localparam logic [3:0] VIP_TYPE_CTRL      = 4'hF;
    localparam logic [3:0] VIP_INTERLACE_PROG = 4'h3;

    localparam logic [1:0] PAT_BARS    = 2'd0;
    localparam logic [1:0] PAT_RAMP    = 2'd1;
    localparam logic [1:0] PAT_SOLID   = 2'd2;
    localparam logic [1:0] PAT_CHECKER = 2'd3;

    // Entry 0 is the leftmost bar; entries are packed highest index first.
    localparam logic [7:0][23:0] BAR_COLORS = {
        24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
        24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
    };

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CTRL_HDR,
        ST_CTRL_DATA,
        ST_VID_HDR,
        ST_PIXELS
    } tpg_state_t;

endpackage

// File: rtl/tpg_pixel_color.sv
// Combinational pixel colour lookup: maps the latched pattern and the raster
// position (only the bits each pattern needs) to a 24-bit {R,G,B} value.
module tpg_pixel_color
    import video_pkg::*;
#(
    parameter logic [23:0] SOLID_RGB = 24'h0000FF
) (
    input  logic [1:0]  pattern,
    input  logic [7:0]  x,
    input  logic        y_b5,
    input  logic [2:0]  bar_idx,
    output logic [23:0] rgb
);

    always_comb begin
        rgb = '0;
        case (pattern)
            PAT_BARS:  rgb = BAR_COLORS[bar_idx];
            PAT_RAMP:  rgb = {x, x, x};
            PAT_SOLID: rgb = SOLID_RGB;
            default:   rgb = (x[5] ^ y_b5) ? 24'hFFFFFF : 24'h000000;
        endcase
    end

endmodule

// File: rtl/video_tpg_gen24.sv
// 24-bit RGB Avalon-ST test pattern generator in VIP packet format: optional
// control packet, then one video packet per frame while enable is held.
module video_tpg_gen24
    import video_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = 1920,
    parameter int unsigned V_ACTIVE  = 1080,
    parameter bit          SEND_CTRL = 1'b1,
    parameter logic [23:0] SOLID_RGB = 24'h0000FF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    output logic [23:0] dout_data,
    output logic        dout_startofpacket,
    output logic        dout_endofpacket,
    output logic        dout_valid,
    input  logic        dout_ready
);

    localparam logic [15:0] W16    = 16'(H_ACTIVE);
    localparam logic [15:0] H16    = 16'(V_ACTIVE);
    localparam logic [15:0] X_LAST = 16'(H_ACTIVE - 1);
    localparam logic [15:0] Y_LAST = 16'(V_ACTIVE - 1);
    // Narrow frames would give a zero bar width; clamp to one pixel.
    localparam int unsigned BW      = (H_ACTIVE / 8 == 0) ? 1 : H_ACTIVE / 8;
    localparam logic [15:0] BW_LAST = 16'(BW - 1);
    localparam tpg_state_t  FIRST_ST = SEND_CTRL ? ST_CTRL_HDR : ST_VID_HDR;

    tpg_state_t  state_q, state_n;
    logic [1:0]  beat_q;
    logic [15:0] x_q, y_q, bar_cnt_q;
    logic [2:0]  bar_idx_q;
    logic [1:0]  pat_q;
    logic        adv, last_x, last_y;
    logic [23:0] pix_rgb;
    logic [23:0] data_p0;
    logic        sop_p0, eop_p0, vld_p0;

    assign adv    = !dout_valid || dout_ready;
    assign last_x = (x_q == X_LAST);
    assign last_y = (y_q == Y_LAST);

    tpg_pixel_color #(.SOLID_RGB(SOLID_RGB)) u_color (
        .pattern (pat_q),
        .x       (x_q[7:0]),
        .y_b5    (y_q[5]),
        .bar_idx (bar_idx_q),
        .rgb     (pix_rgb)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_n;
    end

    // Stage 0: the beat the current state would present next.
    always_comb begin
        state_n = state_q;
        data_p0 = '0;
        sop_p0  = 1'b0;
        eop_p0  = 1'b0;
        vld_p0  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable) state_n = FIRST_ST;
            end
            ST_CTRL_HDR: begin
                vld_p0  = 1'b1;
                sop_p0  = 1'b1;
                data_p0 = {20'h0, VIP_TYPE_CTRL};
                if (adv) state_n = ST_CTRL_DATA;
            end
            ST_CTRL_DATA: begin
                vld_p0 = 1'b1;
                case (beat_q)
                    2'd0:    data_p0 = {4'h0, W16[7:4], 4'h0, W16[11:8], 4'h0, W16[15:12]};
                    2'd1:    data_p0 = {4'h0, H16[11:8], 4'h0, H16[15:12], 4'h0, W16[3:0]};
                    default: data_p0 = {4'h0, VIP_INTERLACE_PROG, 4'h0, H16[3:0], 4'h0, H16[7:4]};
                endcase
                eop_p0 = (beat_q == 2'd2);
                if (adv && eop_p0) state_n = ST_VID_HDR;
            end
            ST_VID_HDR: begin
                vld_p0  = 1'b1;
                sop_p0  = 1'b1;
                data_p0 = {20'h0, VIP_TYPE_VIDEO};
                if (adv) state_n = ST_PIXELS;
            end
            ST_PIXELS: begin
                vld_p0  = 1'b1;
                data_p0 = pix_rgb;
                eop_p0  = last_x && last_y;
                // The EOP beat only leaves once accepted, so the next frame
                // cannot start early even if its state is chosen now.
                if (adv && eop_p0) state_n = enable ? FIRST_ST : ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_q    <= '0;
            x_q       <= '0;
            y_q       <= '0;
            bar_cnt_q <= '0;
            bar_idx_q <= '0;
            pat_q     <= '0;
        end else if (adv) begin
            case (state_q)
                ST_CTRL_DATA: beat_q <= (beat_q == 2'd2) ? 2'd0 : beat_q + 2'd1;
                ST_VID_HDR: begin
                    pat_q     <= pattern_sel;
                    x_q       <= '0;
                    y_q       <= '0;
                    bar_cnt_q <= '0;
                    bar_idx_q <= '0;
                end
                ST_PIXELS: begin
                    if (last_x) begin
                        x_q       <= '0;
                        y_q       <= last_y ? 16'd0 : y_q + 16'd1;
                        bar_cnt_q <= '0;
                        bar_idx_q <= '0;
                    end else begin
                        x_q       <= x_q + 16'd1;
                        bar_cnt_q <= (bar_cnt_q == BW_LAST) ? 16'd0 : bar_cnt_q + 16'd1;
                        if (bar_cnt_q == BW_LAST && bar_idx_q != 3'd7)
                            bar_idx_q <= bar_idx_q + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Stage 1: registered stream outputs, held while the sink stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout_data          <= '0;
            dout_startofpacket <= 1'b0;
            dout_endofpacket   <= 1'b0;
            dout_valid         <= 1'b0;
        end else if (adv) begin
            dout_data          <= data_p0;
            dout_startofpacket <= sop_p0;
            dout_endofpacket   <= eop_p0;
            dout_valid         <= vld_p0;
        end
    end

endmodule

// File: tb/tb_video_tpg_gen24.sv
// Directed bench for video_tpg_gen24: four parameterisations run side by side
// on one clock, accepted beats captured and compared against hand-built tables.
module tb_video_tpg_gen24;

    typedef struct {
        logic [23:0] data;
        logic        sop;
        logic        eop;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    // A: H=16 V=2 with control packets
    logic        rst_a = 1'b1, en_a = 1'b0, rdy_a = 1'b1;
    logic [1:0]  sel_a = 2'd0;
    logic [23:0] data_a;
    logic        sop_a, eop_a, vld_a;

    // B/C/D share reset, enable and an always-ready sink
    logic        rst_o = 1'b1, en_o = 1'b0, rdy_o = 1'b1;
    logic [1:0]  sel_b = 2'd1, sel_c = 2'd3, sel_d = 2'd0;
    logic [23:0] data_b, data_c, data_d;
    logic        sop_b, eop_b, vld_b, sop_c, eop_c, vld_c, sop_d, eop_d, vld_d;

    video_tpg_gen24 #(.H_ACTIVE(16), .V_ACTIVE(2), .SEND_CTRL(1'b1), .SOLID_RGB(24'h0000FF)) dut_a (
        .clk(clk), .reset(rst_a), .enable(en_a), .pattern_sel(sel_a),
        .dout_data(data_a), .dout_startofpacket(sop_a), .dout_endofpacket(eop_a),
        .dout_valid(vld_a), .dout_ready(rdy_a));

    video_tpg_gen24 #(.H_ACTIVE(300), .V_ACTIVE(2), .SEND_CTRL(1'b0), .SOLID_RGB(24'h0000FF)) dut_b (
        .clk(clk), .reset(rst_o), .enable(en_o), .pattern_sel(sel_b),
        .dout_data(data_b), .dout_startofpacket(sop_b), .dout_endofpacket(eop_b),
        .dout_valid(vld_b), .dout_ready(rdy_o));

    video_tpg_gen24 #(.H_ACTIVE(64), .V_ACTIVE(64), .SEND_CTRL(1'b0), .SOLID_RGB(24'h0000FF)) dut_c (
        .clk(clk), .reset(rst_o), .enable(en_o), .pattern_sel(sel_c),
        .dout_data(data_c), .dout_startofpacket(sop_c), .dout_endofpacket(eop_c),
        .dout_valid(vld_c), .dout_ready(rdy_o));

    video_tpg_gen24 #(.H_ACTIVE(17), .V_ACTIVE(1), .SEND_CTRL(1'b0), .SOLID_RGB(24'h0000FF)) dut_d (
        .clk(clk), .reset(rst_o), .enable(en_o), .pattern_sel(sel_d),
        .dout_data(data_d), .dout_startofpacket(sop_d), .dout_endofpacket(eop_d),
        .dout_valid(vld_d), .dout_ready(rdy_o));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Capture accepted beats; on A also verify beats hold while stalled.
    beat_t qa[$], qb[$], qc[$], qd[$];
    logic        rec_a = 1'b0;
    logic        stall_a = 1'b0;
    logic [26:0] prev_a = '0;

    always @(negedge clk) begin
        if (rec_a && !rst_a) begin
            if (stall_a) check("stall_hold_a", 32'({vld_a, sop_a, eop_a, data_a}), 32'(prev_a));
            if (vld_a && rdy_a) qa.push_back('{data_a, sop_a, eop_a});
            stall_a = vld_a && !rdy_a;
            prev_a  = {vld_a, sop_a, eop_a, data_a};
        end else begin
            stall_a = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!rst_o) begin
            if (vld_b) qb.push_back('{data_b, sop_b, eop_b});
            if (vld_c) qc.push_back('{data_c, sop_c, eop_c});
            if (vld_d) qd.push_back('{data_d, sop_d, eop_d});
        end
    end

    function automatic logic [31:0] pk(input beat_t b);
        return 32'({b.sop, b.eop, b.data});
    endfunction

    initial begin
        beat_t exp_a [37];
        beat_t exp_d [18];
        int base, lat, cyc, idx;

        exp_a[0] = '{24'h00000F, 1'b1, 1'b0};
        exp_a[1] = '{24'h010000, 1'b0, 1'b0};
        exp_a[2] = '{24'h000000, 1'b0, 1'b0};
        exp_a[3] = '{24'h030200, 1'b0, 1'b1};
        exp_a[4] = '{24'h000000, 1'b1, 1'b0};
        for (int i = 0; i < 32; i++) exp_a[5 + i] = '{bars[(i % 16) / 2], 1'b0, (i == 31)};
        exp_d[0] = '{24'h000000, 1'b1, 1'b0};
        for (int x = 0; x < 17; x++) exp_d[1 + x] = '{bars[(x / 2 > 7) ? 7 : x / 2], 1'b0, (x == 16)};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_a", 32'({vld_a, sop_a, eop_a, data_a}), 32'd0);
        check("reset_out_d", 32'({vld_d, sop_d, eop_d, data_d}), 32'd0);
        rst_a = 1'b0;
        rst_o = 1'b0;
        repeat (2) @(posedge clk);

        // Run 1: ready held high, one frame, enable dropped mid-frame
        #1;
        rec_a = 1'b1;
        base  = qa.size();
        en_a  = 1'b1;
        en_o  = 1'b1;
        lat   = 0;
        while (!vld_a && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("first_beat_latency_le2", 32'(lat <= 2), 32'd1);
        en_a = 1'b0;
        en_o = 1'b0;
        cyc  = 0;
        while (qa.size() - base < 37 && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        repeat (6) @(posedge clk);
        #1;
        check("run1_beat_count", 32'(qa.size() - base), 32'd37);
        check("run1_idle_after_eop", 32'(vld_a), 32'd0);
        for (int i = 0; i < 37; i++)
            if (base + i < qa.size())
                check($sformatf("run1_beat%0d", i), pk(qa[base + i]), pk(exp_a[i]));

        // Run 2: random ready; pattern_sel changed mid-frame must not matter
        base  = qa.size();
        en_a  = 1'b1;
        cyc   = 0;
        while (qa.size() - base < 37 && cyc < 2000) begin
            @(posedge clk);
            #1;
            rdy_a = 1'($urandom_range(0, 1));
            cyc++;
            if (cyc == 3) en_a = 1'b0;
            if (qa.size() - base == 20) sel_a = 2'd2;
        end
        rdy_a = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("run2_beat_count", 32'(qa.size() - base), 32'd37);
        check("run2_idle_after_eop", 32'(vld_a), 32'd0);
        for (int i = 0; i < 37; i++)
            if (base + i < qa.size())
                check($sformatf("run2_beat%0d", i), pk(qa[base + i]), pk(exp_a[i]));

        // Run 3: asynchronous reset during pixels, then restart from the header
        sel_a = 2'd0;
        base  = qa.size();
        en_a  = 1'b1;
        cyc   = 0;
        while (qa.size() - base < 10 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        #2;
        rst_a = 1'b1;
        #1;
        check("async_reset_out_a", 32'({vld_a, sop_a, eop_a, data_a}), 32'd0);
        @(posedge clk);
        #1;
        rst_a = 1'b0;
        base  = qa.size();
        cyc   = 0;
        while (qa.size() - base < 5 && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("restart_beat_count", 32'(qa.size() - base >= 5), 32'd1);
        for (int i = 0; i < 5; i++)
            if (base + i < qa.size())
                check($sformatf("restart_beat%0d", i), pk(qa[base + i]), pk(exp_a[i]));
        en_a = 1'b0;

        // B, C, D: single frames started in run 1
        cyc = 0;
        while (qc.size() < 4097 && cyc < 6000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        repeat (6) @(posedge clk);
        #1;
        check("ramp_beat_count", 32'(qb.size()), 32'd601);
        check("checker_beat_count", 32'(qc.size()), 32'd4097);
        check("bars17_beat_count", 32'(qd.size()), 32'd18);
        check("outputs_idle_bcd", 32'({vld_b, vld_c, vld_d}), 32'd0);
        if (qb.size() == 601) begin
            check("ramp_vid_hdr", pk(qb[0]), 32'({1'b1, 1'b0, 24'h000000}));
            check("ramp_x0", pk(qb[1]), 32'({1'b0, 1'b0, 24'h000000}));
            check("ramp_x255", pk(qb[1 + 255]), 32'({1'b0, 1'b0, 24'hFFFFFF}));
            check("ramp_x256", pk(qb[1 + 256]), 32'({1'b0, 1'b0, 24'h000000}));
            check("ramp_x299", pk(qb[1 + 299]), 32'({1'b0, 1'b0, 24'h2B2B2B}));
            check("ramp_eop", pk(qb[600]), 32'({1'b0, 1'b1, 24'h2B2B2B}));
        end
        if (qc.size() == 4097) begin
            check("checker_vid_hdr", pk(qc[0]), 32'({1'b1, 1'b0, 24'h000000}));
            idx = 1 + 0 * 64 + 32;
            check("checker_32_0", pk(qc[idx]), 32'({1'b0, 1'b0, 24'hFFFFFF}));
            idx = 1 + 32 * 64 + 32;
            check("checker_32_32", pk(qc[idx]), 32'({1'b0, 1'b0, 24'h000000}));
            idx = 1 + 32 * 64 + 0;
            check("checker_0_32", pk(qc[idx]), 32'({1'b0, 1'b0, 24'hFFFFFF}));
            check("checker_eop", pk(qc[4096]), 32'({1'b0, 1'b1, 24'h000000}));
        end
        for (int i = 0; i < 18; i++)
            if (i < qd.size())
                check($sformatf("bars17_beat%0d", i), pk(qd[i]), pk(exp_d[i]));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
